// File: rtl/breakout_pixel_gen.sv
// breakout_pixel_gen: Breakout game core (paddle, ball, bricks) with a registered
// 4-bit RGB pixel path and one-pixel-delayed sync outputs.
// Define BREAKOUT_BRICKS_EN to build the brick row; otherwise bricksLeft reads 0.
module breakout_pixel_gen (
    input  logic       clock,
    input  logic       reset,
    input  logic       pTick,
    input  logic       videoON,
    input  logic [9:0] pixelX,
    input  logic [9:0] pixelY,
    input  logic       hSync,
    input  logic       vSync,
    input  logic       btnLeft,
    input  logic       btnRight,
    input  logic       btnLaunch,
    output logic [3:0] vgaRed,
    output logic [3:0] vgaGreen,
    output logic [3:0] vgaBlue,
    output logic       hSyncDly,
    output logic       vSyncDly,
    output logic       ballLost,
    output logic [3:0] bricksLeft
);
    localparam int unsigned H_ACTIVE    = 640;
    localparam int unsigned V_ACTIVE    = 480;
    localparam int unsigned WALL_W      = 16;
    localparam int unsigned PADDLE_W    = 64;
    localparam int unsigned PADDLE_H    = 8;
    localparam int unsigned PADDLE_Y    = 448;
    localparam int unsigned PADDLE_V    = 4;
    localparam int unsigned BALL_SIZE   = 8;
    localparam int unsigned BALL_V      = 2;
    localparam int unsigned LOST_FRAMES = 60;
    localparam int unsigned PADDLE_MAX  = H_ACTIVE - WALL_W - PADDLE_W;

    localparam logic [1:0] S_SERVE = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_LOST  = 2'd2;

    logic [1:0]        state, state_nx;
    logic [9:0]        paddle_x, paddle_nx;
    logic [9:0]        ball_x, ball_x_nx, ball_y, ball_y_nx;
    logic              dx_neg, dx_neg_nx, dy_neg, dy_neg_nx;
    logic [5:0]        lost_cnt, lost_cnt_nx;
    logic              lost_nx;
    logic signed [10:0] vel_x, vel_y, sum_x, sum_y;
    logic              frame_tick_c, paddle_hit_c;
    logic              ball_px_c, paddle_px_c, wall_px_c, brick_px_c, brick_any_c;
    logic [11:0]       colour_c;

    assign frame_tick_c = pTick && (pixelX == 10'(0)) && (pixelY == 10'(V_ACTIVE + 1));

`ifdef BREAKOUT_BRICKS_EN
    localparam int unsigned NUM_BRICKS = 8;
    localparam int unsigned BRICK_W    = 76;
    localparam int unsigned BRICK_Y0   = 64;
    localparam int unsigned BRICK_Y1   = 80;

    logic [7:0] brick_map, brick_map_nx, brick_hit_c, brick_clr_c;
    logic [3:0] bricks_left;

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
        return n;
    endfunction

    // Ball-box and current-pixel overlap against each live brick
    always_comb begin
        brick_hit_c = '0;
        brick_px_c  = 1'b0;
        for (int i = 0; i < NUM_BRICKS; i++) begin
            if (brick_map[i]
                && (ball_y + 10'(BALL_SIZE) > 10'(BRICK_Y0)) && (ball_y < 10'(BRICK_Y1))
                && (ball_x + 10'(BALL_SIZE) > 10'(WALL_W + BRICK_W * i))
                && (ball_x < 10'(WALL_W + BRICK_W * (i + 1))))
                brick_hit_c[i] = 1'b1;
            if (brick_map[i]
                && (pixelY >= 10'(BRICK_Y0)) && (pixelY < 10'(BRICK_Y1))
                && (pixelX >= 10'(WALL_W + BRICK_W * i))
                && (pixelX < 10'(WALL_W + BRICK_W * (i + 1))))
                brick_px_c = 1'b1;
        end
    end

    // Only the lowest-index overlapping brick is cleared
    assign brick_clr_c = brick_hit_c & (~brick_hit_c + 8'd1);
    assign brick_any_c = |brick_hit_c;
    assign bricksLeft  = bricks_left;
`else
    assign brick_px_c  = 1'b0;
    assign brick_any_c = 1'b0;
    assign bricksLeft  = 4'd0;
`endif

    assign paddle_hit_c = !dy_neg
        && (ball_y + 10'(BALL_SIZE) >= 10'(PADDLE_Y))
        && (ball_y + 10'(BALL_SIZE) < 10'(PADDLE_Y + PADDLE_H))
        && (ball_x < paddle_x + 10'(PADDLE_W))
        && (ball_x + 10'(BALL_SIZE) > paddle_x);

    // Next game state, evaluated once per frame tick
    always_comb begin
        state_nx    = state;
        paddle_nx   = paddle_x;
        ball_x_nx   = ball_x;
        ball_y_nx   = ball_y;
        dx_neg_nx   = dx_neg;
        dy_neg_nx   = dy_neg;
        lost_cnt_nx = lost_cnt;
        lost_nx     = 1'b0;
        vel_x       = '0;
        vel_y       = '0;
        sum_x       = '0;
        sum_y       = '0;
`ifdef BREAKOUT_BRICKS_EN
        brick_map_nx = brick_map;
`endif
        if (frame_tick_c) begin
            if (btnLeft && !btnRight)
                paddle_nx = (paddle_x >= 10'(WALL_W + PADDLE_V)) ? paddle_x - 10'(PADDLE_V) : 10'(WALL_W);
            else if (btnRight && !btnLeft)
                paddle_nx = (paddle_x <= 10'(PADDLE_MAX - PADDLE_V)) ? paddle_x + 10'(PADDLE_V) : 10'(PADDLE_MAX);

            case (state)
                S_SERVE: begin
                    ball_x_nx = paddle_nx + 10'(PADDLE_W / 2 - BALL_SIZE / 2);
                    ball_y_nx = 10'(PADDLE_Y - BALL_SIZE);
                    if (btnLaunch) begin
                        state_nx  = S_PLAY;
                        dx_neg_nx = 1'b0;
                        dy_neg_nx = 1'b1;
                    end
                end
                S_PLAY: begin
                    if (ball_y + 10'(BALL_SIZE) >= 10'(V_ACTIVE)) begin
                        state_nx    = S_LOST;
                        lost_nx     = 1'b1;
                        lost_cnt_nx = '0;
                    end else begin
                        if (ball_x <= 10'(WALL_W))
                            dx_neg_nx = 1'b0;
                        else if (ball_x + 10'(BALL_SIZE) >= 10'(H_ACTIVE - WALL_W))
                            dx_neg_nx = 1'b1;
                        if (ball_y <= 10'(WALL_W))
                            dy_neg_nx = 1'b0;
                        else if (brick_any_c)
                            dy_neg_nx = !dy_neg;
                        else if (paddle_hit_c)
                            dy_neg_nx = 1'b1;
`ifdef BREAKOUT_BRICKS_EN
                        brick_map_nx = brick_map & ~brick_clr_c;
`endif
                        vel_x     = dx_neg_nx ? -$signed(11'(BALL_V)) : $signed(11'(BALL_V));
                        vel_y     = dy_neg_nx ? -$signed(11'(BALL_V)) : $signed(11'(BALL_V));
                        sum_x     = $signed({1'b0, ball_x}) + vel_x;
                        sum_y     = $signed({1'b0, ball_y}) + vel_y;
                        ball_x_nx = 10'(sum_x);
                        ball_y_nx = 10'(sum_y);
                    end
                end
                S_LOST: begin
                    if (lost_cnt == 6'(LOST_FRAMES - 1)) begin
                        state_nx  = S_SERVE;
                        ball_x_nx = paddle_nx + 10'(PADDLE_W / 2 - BALL_SIZE / 2);
                        ball_y_nx = 10'(PADDLE_Y - BALL_SIZE);
`ifdef BREAKOUT_BRICKS_EN
                        brick_map_nx = 8'hFF;
`endif
                    end else begin
                        lost_cnt_nx = lost_cnt + 6'd1;
                    end
                end
                default: state_nx = S_SERVE;
            endcase
        end
    end

    // Game state register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= S_SERVE;
            paddle_x <= 10'((H_ACTIVE - PADDLE_W) / 2);
            ball_x   <= 10'((H_ACTIVE - PADDLE_W) / 2 + PADDLE_W / 2 - BALL_SIZE / 2);
            ball_y   <= 10'(PADDLE_Y - BALL_SIZE);
            dx_neg   <= 1'b0;
            dy_neg   <= 1'b1;
            lost_cnt <= '0;
            ballLost <= 1'b0;
`ifdef BREAKOUT_BRICKS_EN
            brick_map   <= 8'hFF;
            bricks_left <= 4'd8;
`endif
        end else begin
            state    <= state_nx;
            paddle_x <= paddle_nx;
            ball_x   <= ball_x_nx;
            ball_y   <= ball_y_nx;
            dx_neg   <= dx_neg_nx;
            dy_neg   <= dy_neg_nx;
            lost_cnt <= lost_cnt_nx;
            ballLost <= lost_nx;
`ifdef BREAKOUT_BRICKS_EN
            brick_map   <= brick_map_nx;
            bricks_left <= popcnt8(brick_map_nx);
`endif
        end
    end

    // Colour of the current pixel, ball over paddle over brick over wall
    always_comb begin
        ball_px_c   = (state != S_LOST)
                      && (pixelX >= ball_x) && (pixelX < ball_x + 10'(BALL_SIZE))
                      && (pixelY >= ball_y) && (pixelY < ball_y + 10'(BALL_SIZE));
        paddle_px_c = (pixelX >= paddle_x) && (pixelX < paddle_x + 10'(PADDLE_W))
                      && (pixelY >= 10'(PADDLE_Y)) && (pixelY < 10'(PADDLE_Y + PADDLE_H));
        wall_px_c   = (pixelX < 10'(WALL_W)) || (pixelX >= 10'(H_ACTIVE - WALL_W))
                      || (pixelY < 10'(WALL_W));
        if (ball_px_c)        colour_c = 12'hFFF;
        else if (paddle_px_c) colour_c = 12'h00F;
        else if (brick_px_c)  colour_c = 12'hF00;
        else if (wall_px_c)   colour_c = 12'h888;
        else                  colour_c = 12'h000;
    end

    // Pixel output and sync delay, advanced on each pixel tick
    always_ff @(posedge clock) begin
        if (!reset) begin
            {vgaRed, vgaGreen, vgaBlue} <= 12'h000;
            hSyncDly <= 1'b0;
            vSyncDly <= 1'b0;
        end else if (pTick) begin
            {vgaRed, vgaGreen, vgaBlue} <= videoON ? colour_c : 12'h000;
            hSyncDly <= hSync;
            vSyncDly <= vSync;
        end
    end
endmodule
